// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one ripple adder among NUM_REQ requesters.
// Results land in a one-entry output register with a valid/ready handshake.

module adder_nbit #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic            cin_i,
    output logic [SIZE-1:0] sum_o,
    output logic            cout_o
);
    logic [SIZE:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[SIZE];
endmodule

module adder_rr_scheduler #(
    parameter  int SIZE    = 16,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_cin,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SIZE-1:0]         res_sum,
    output logic                    res_cout,
    output logic [ID_W-1:0]         res_id
);
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               res_valid_q, res_valid_d;
    logic [SIZE-1:0]    res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;

    logic               slot_free;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_vec;
    logic [SIZE-1:0]    add_a, add_b;
    logic               add_cin;
    logic [SIZE-1:0]    add_sum;
    logic               add_cout;

    // Reset is folded in so no grant is visible while n_rst is held low.
    assign slot_free = n_rst & (~res_valid_q | res_ready);

    always_comb begin
        logic [ID_W:0]   pos;
        logic [ID_W-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_vec = '0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ))
                pos = pos - (ID_W+1)'(NUM_REQ);
            idx = pos[ID_W-1:0];
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (!slot_free)
            grant_any = 1'b0;
        if (grant_any)
            grant_vec[grant_id] = 1'b1;
    end

    assign req_ready = grant_vec;

    // One-hot AND-OR mux: operands are zero when nothing is granted.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                add_a   = add_a | req_a[i*SIZE +: SIZE];
                add_b   = add_b | req_b[i*SIZE +: SIZE];
                add_cin = add_cin | req_cin[i];
            end
        end
    end

    adder_nbit #(.SIZE(SIZE)) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        if (grant_any) begin
            res_valid_d = 1'b1;
            res_sum_d   = add_sum;
            res_cout_d  = add_cout;
            res_id_d    = grant_id;
            ptr_d       = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: per-cycle reference model plus directed literal checks,
// with a second SIZE=1 / NUM_REQ=3 instance for the parameter corner.

module tb_adder_rr_scheduler;
    localparam int S = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_cin, req_ready;
    logic [N*S-1:0] req_a, req_b;
    logic           res_valid, res_ready, res_cout;
    logic [S-1:0]   res_sum;
    logic [1:0]     res_id;

    logic [2:0]     v2, a2, b2, cin2, rdy2;
    logic           rv2, rr2, rs2, rc2;
    logic [1:0]     rid2;

    int errs = 0;
    int checks = 0;

    adder_rr_scheduler #(.SIZE(S), .NUM_REQ(N)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    adder_rr_scheduler #(.SIZE(1), .NUM_REQ(3)) dut2 (
        .clk(clk), .n_rst(n_rst),
        .req_valid(v2), .req_a(a2), .req_b(b2), .req_cin(cin2),
        .req_ready(rdy2),
        .res_valid(rv2), .res_ready(rr2),
        .res_sum(rs2), .res_cout(rc2), .res_id(rid2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pointer, result slot and round-robin search from the rules.
    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [S-1:0] m_sum = '0;
    bit          m_cout = 0;
    int          m_id = 0;

    function automatic int model_grant();
        if (n_rst !== 1'b1) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_ptr = 0; m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0;
        end else begin
            int g;
            logic [S:0] full;
            g = model_grant();
            if (g >= 0) begin
                full = {1'b0, req_a[g*S +: S]} + {1'b0, req_b[g*S +: S]} + (S+1)'(req_cin[g]);
                m_sum = full[S-1:0];
                m_cout = full[S];
                m_id = g;
                m_valid = 1;
                m_ptr = (g + 1) % N;
            end else if (res_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = model_grant();
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_sum",   32'(res_sum),   32'(m_sum));
        chk("res_cout",  32'(res_cout),  32'(m_cout));
        chk("res_id",    32'(res_id),    32'(m_id));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [S-1:0] a,
                           input logic [S-1:0] b, input bit c);
        req_valid[i] = v;
        req_a[i*S +: S] = a;
        req_b[i*S +: S] = b;
        req_cin[i] = c;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    logic [S-1:0] rr_sum [4] = '{16'h1000, 16'h2001, 16'h3002, 16'h4003};
    logic [1:0]   rr_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0]   sk_id  [3] = '{2'd1, 2'd3, 2'd1};
    logic [1:0]   sw_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    initial begin
        req_valid = '0; req_cin = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        v2 = '0; a2 = '0; b2 = '0; cin2 = '0; rr2 = 1'b0;
        tick();
        chk("reset_valid", 32'(res_valid), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);

        // Reset mid-transfer with a held result from requester 2.
        do_reset();
        set_req(2, 1, 16'd5, 16'd7, 0);
        tick();
        chk("pre_rst_sum", 32'(res_sum), 32'd12);
        chk("pre_rst_id",  32'(res_id),  32'd2);
        set_req(2, 0, 16'd0, 16'd0, 0);
        set_req(0, 1, 16'd5, 16'd7, 0);
        n_rst = 1'b0;
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum",   32'(res_sum),   32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        chk("post_rst_sum",  32'(res_sum),  32'd12);
        chk("post_rst_cout", 32'(res_cout), 32'd0);
        chk("post_rst_id",   32'(res_id),   32'd0);

        // Round-robin with all requesters valid and a free consumer.
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 16'((i + 1) * 4096), 16'(i), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_id",    32'(res_id),    32'(rr_id[k]));
            chk("rr_sum",   32'(res_sum),   32'(rr_sum[rr_id[k]]));
            chk("rr_valid", 32'(res_valid), 32'd1);
        end

        // Skip idle requesters, then raise req2 once the pointer is at 2.
        do_reset();
        res_ready = 1'b1;
        set_req(1, 1, 16'd10, 16'd1, 0);
        set_req(3, 1, 16'd30, 16'd3, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("skip_id", 32'(res_id), 32'(sk_id[k]));
        end
        set_req(2, 1, 16'd20, 16'd2, 0);
        tick();
        chk("skip_req2_id",  32'(res_id),  32'd2);
        chk("skip_req2_sum", 32'(res_sum), 32'd22);

        // Backpressure: held result blocks req2 until the consumer frees the slot.
        do_reset();
        set_req(0, 1, 16'h0123, 16'h0100, 0);
        tick();
        set_req(0, 0, 16'd0, 16'd0, 0);
        set_req(2, 1, 16'h0200, 16'h0022, 1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_sum",   32'(res_sum),   32'h0223);
            chk("bp_id",    32'(res_id),    32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("bp_new_id",  32'(res_id),  32'd2);
        chk("bp_new_sum", 32'(res_sum), 32'h0223);
        set_req(2, 0, 16'd0, 16'd0, 0);
        tick();
        chk("bp_drain", 32'(res_valid), 32'd0);

        // Overflow with carry-in through requester 3.
        do_reset();
        set_req(3, 1, 16'hFFFF, 16'h0001, 1);
        tick();
        chk("ovf_sum",  32'(res_sum),  32'h0001);
        chk("ovf_cout", 32'(res_cout), 32'd1);
        chk("ovf_id",   32'(res_id),   32'd3);
        set_req(3, 0, 16'd0, 16'd0, 0);

        // SIZE=1, NUM_REQ=3 instance: pointer wraps 2 -> 0.
        do_reset();
        v2 = 3'b111; a2 = 3'b111; b2 = 3'b111; cin2 = 3'b111; rr2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sw_id",    32'(rid2), 32'(sw_id[k]));
            chk("sw_sum",   32'(rs2),  32'd1);
            chk("sw_cout",  32'(rc2),  32'd1);
            chk("sw_valid", 32'(rv2),  32'd1);
        end
        v2 = '0;

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
